// File: rtl/noc_rr_arbiter_n.sv
// Generic circular FIFO: registered storage, head visible the edge after push.
// Caller must not push when full unless popping in the same cycle.
module noc_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_vld,
    output logic [WIDTH-1:0] head_dat,
    output logic [CW-1:0]    count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign head_dat = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_vld) rd_ptr <= rd_ptr + AW'(1);
            if (push_vld && !pop_vld)      count <= count + CW'(1);
            else if (!push_vld && pop_vld) count <= count - CW'(1);
        end
    end
endmodule

// NUM_IN-way round-robin / fixed-priority flit arbiter feeding an output FIFO.
// One-cycle latency to out_data; in_ready drops only when the FIFO is full and not popping.
module noc_rr_arbiter_n #(
    parameter int NUM_IN = 5,
    parameter int WIDTH  = 11,
    parameter int DEPTH  = 4,
    parameter int MODE   = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_IN-1:0]         in_valid,
    input  logic [NUM_IN*WIDTH-1:0]   in_data,
    output logic [NUM_IN-1:0]         in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    input  logic                      out_ready,
    output logic [$clog2(NUM_IN)-1:0] grant_id,
    output logic [$clog2(DEPTH):0]    fifo_count
);
    localparam int GW = $clog2(NUM_IN);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] flit [NUM_IN];
    logic [GW-1:0]    rr_ptr;
    logic [GW-1:0]    base;
    logic [GW-1:0]    win_idx;
    logic [GW:0]      cand;
    logic             win_vld;
    logic             space;
    logic             accept;
    logic             pop;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_unpack
        assign flit[i] = in_data[i*WIDTH +: WIDTH];
    end

    assign base  = (MODE == 0) ? rr_ptr : '0;
    assign pop   = out_valid && out_ready;
    assign space = (fifo_count < CW'(DEPTH)) || pop;

    // Scan from base upward with wrap; the first requester wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            cand = {1'b0, base} + (GW+1)'(k);
            if (cand >= (GW+1)'(NUM_IN)) cand = cand - (GW+1)'(NUM_IN);
            if (!win_vld && in_valid[cand[GW-1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[GW-1:0];
            end
        end
    end

    assign accept = rst_n && space && win_vld;

    always_comb begin
        in_ready = '0;
        if (accept) in_ready[win_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            grant_id <= '0;
        end else if (accept) begin
            grant_id <= win_idx;
            if (MODE == 0)
                rr_ptr <= (win_idx == GW'(NUM_IN-1)) ? '0 : win_idx + GW'(1);
        end
    end

    noc_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (accept),
        .push_dat (flit[win_idx]),
        .pop_vld  (pop),
        .head_dat (out_data),
        .count    (fifo_count)
    );

    assign out_valid = (fifo_count != '0);
endmodule

// File: tb/tb_noc_rr_arbiter_n.sv
// Directed bench: round-robin instance (u_rr) and fixed-priority instance (u_fp) share stimulus.
module tb_noc_rr_arbiter_n;
    logic        clk;
    logic        rst_n;
    logic [4:0]  in_valid;
    logic [54:0] in_data;
    logic        out_ready;

    logic [4:0]  rr_in_ready, fp_in_ready;
    logic        rr_out_valid, fp_out_valid;
    logic [10:0] rr_out_data, fp_out_data;
    logic [2:0]  rr_grant_id, fp_grant_id;
    logic [2:0]  rr_fifo_count, fp_fifo_count;

    int checks = 0;
    int errors = 0;

    noc_rr_arbiter_n #(.NUM_IN(5), .WIDTH(11), .DEPTH(4), .MODE(0)) u_rr (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rr_in_ready), .out_valid(rr_out_valid), .out_data(rr_out_data),
        .out_ready(out_ready), .grant_id(rr_grant_id), .fifo_count(rr_fifo_count));

    noc_rr_arbiter_n #(.NUM_IN(5), .WIDTH(11), .DEPTH(4), .MODE(1)) u_fp (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(fp_in_ready), .out_valid(fp_out_valid), .out_data(fp_out_data),
        .out_ready(out_ready), .grant_id(fp_grant_id), .fifo_count(fp_fifo_count));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] flit_val(input int i);
        return 11'h700 + 11'(i);
    endfunction

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        in_valid  = 5'b11111;
        for (int i = 0; i < 5; i++) in_data[i*11 +: 11] = flit_val(i);

        // Reset values, with requests already present
        #3;
        check("rst_out_valid", 32'(rr_out_valid), 0);
        check("rst_out_data", 32'(rr_out_data), 0);
        check("rst_fifo_count", 32'(rr_fifo_count), 0);
        check("rst_grant_id", 32'(rr_grant_id), 0);
        check("rst_in_ready", 32'(rr_in_ready), 0);

        @(negedge clk);
        rst_n = 1'b1;

        // 1: all valid, out_ready high -> 0,1,2,3,4,0,... with count pinned at 1
        for (int k = 0; k < 10; k++) begin
            #1;
            check("t1_in_ready", 32'(rr_in_ready), 32'(5'b00001 << (k % 5)));
            tick();
            check("t1_grant_id", 32'(rr_grant_id), 32'(k % 5));
            check("t1_out_valid", 32'(rr_out_valid), 1);
            check("t1_out_data", 32'(rr_out_data), 32'(flit_val(k % 5)));
            check("t1_fifo_count", 32'(rr_fifo_count), 1);
        end

        // 2: lone request on input 3
        in_valid = 5'b01000;
        in_data[3*11 +: 11] = 11'h5A3;
        #1;
        check("t2_in_ready", 32'(rr_in_ready), 32'(5'b01000));
        tick();
        check("t2_out_valid", 32'(rr_out_valid), 1);
        check("t2_out_data", 32'(rr_out_data), 32'h5A3);
        check("t2_grant_id", 32'(rr_grant_id), 3);
        in_data[3*11 +: 11] = flit_val(3);
        in_valid = 5'b11111;
        #1;
        check("t2_ptr_is_4", 32'(rr_in_ready), 32'(5'b10000));
        tick();
        check("t2_grant4", 32'(rr_grant_id), 4);
        check("t2_data4", 32'(rr_out_data), 32'(flit_val(4)));
        in_valid = 5'b00000;
        tick();
        check("t2_drained_count", 32'(rr_fifo_count), 0);
        check("t2_drained_valid", 32'(rr_out_valid), 0);

        // 3: stalled output fills the FIFO from inputs 0..3, then freezes
        out_ready = 1'b0;
        in_valid  = 5'b11111;
        for (int j = 0; j < 6; j++) begin
            #1;
            check("t3_in_ready", 32'(rr_in_ready), (j < 4) ? 32'(5'b00001 << j) : 0);
            tick();
            check("t3_fifo_count", 32'(rr_fifo_count), (j < 4) ? 32'(j + 1) : 4);
            check("t3_grant_id", 32'(rr_grant_id), (j < 4) ? 32'(j) : 3);
            check("t3_head", 32'(rr_out_data), 32'(flit_val(0)));
        end
        out_ready = 1'b1;
        #1;
        check("t3_full_pop_rdy", 32'(rr_in_ready), 32'(5'b10000));
        tick();
        check("t3_full_grant", 32'(rr_grant_id), 4);
        check("t3_full_count", 32'(rr_fifo_count), 4);
        check("t3_full_head", 32'(rr_out_data), 32'(flit_val(1)));

        // 6: drain, move pointer to 2, then input 2 withdraws
        in_valid = 5'b00000;
        for (int j = 0; j < 4; j++) tick();
        check("t6_drained", 32'(rr_fifo_count), 0);
        in_valid = 5'b00010;
        tick();
        check("t6_grant1", 32'(rr_grant_id), 1);
        in_valid = 5'b10100;
        #1;
        check("t6_ptr2_rdy", 32'(rr_in_ready), 32'(5'b00100));
        in_valid = 5'b10000;
        #1;
        check("t6_withdraw_rdy", 32'(rr_in_ready), 32'(5'b10000));
        tick();
        check("t6_grant4", 32'(rr_grant_id), 4);
        in_valid = 5'b11111;
        #1;
        check("t6_ptr0_rdy", 32'(rr_in_ready), 32'(5'b00001));

        // 5: async reset mid-stream with three flits buffered
        out_ready = 1'b0;
        tick();
        tick();
        check("t5_count_before", 32'(rr_fifo_count), 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_out_valid", 32'(rr_out_valid), 0);
        check("t5_fifo_count", 32'(rr_fifo_count), 0);
        check("t5_grant_id", 32'(rr_grant_id), 0);
        check("t5_in_ready", 32'(rr_in_ready), 0);
        rst_n = 1'b1;
        #1;
        check("t5_ptr_reset", 32'(rr_in_ready), 32'(5'b00001));

        // 4: fixed priority, lowest valid index always wins
        out_ready = 1'b1;
        in_valid  = 5'b10110;
        for (int j = 0; j < 4; j++) begin
            #1;
            check("t4_in_ready", 32'(fp_in_ready), 32'(5'b00010));
            tick();
            check("t4_grant_id", 32'(fp_grant_id), 1);
            check("t4_out_data", 32'(fp_out_data), 32'(flit_val(1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
